score_display_scan: RTL and testbench
=====================================

// Module: score_display_scan
// PURPOSE
//   Time-multiplexed 7-segment driver for the 5-digit decimal score. Consumes the BCD digit
//   vector produced by the score-to-digit converter and scans one digit per slot on the
//   board's common-anode display. Each slot has a blanking guard to suppress ghosting. Digits
//   are snapshotted once per frame, so a score change mid-scan never tears the display.
// PARAMETERS
//   NUM_DIGITS   5           number of digits scanned (digit 0 = units, rightmost)
//   CLK_HZ       50_000_000  clk frequency in Hz
//   SLOT_HZ      1000        per-digit slot rate; slot length TICKS = CLK_HZ/SLOT_HZ cycles
//   BLANK_CYCLES 16          cycles at the start of each slot with all anodes off
//   ACTIVE_LOW   1           1: an/seg active-low; 0: active-high
// PORTS
//   clk          in   1              system clock
//   rst          in   1              synchronous, active-high reset
//   digits_in    in   4*NUM_DIGITS   digit i on [4i+3:4i], BCD 0-9; 10-15 tolerated
//   an           out  NUM_DIGITS     anode enables; bit i selects digit i
//   seg          out  7              segments {g,f,e,d,c,b,a}
//   frame_start  out  1              1-cycle pulse when digits_in is snapshotted
// BEHAVIOUR
//   - Reset: an and seg all inactive, frame_start=0, idx=0, slot counter=0, snapshot=all 0,
//     FSM=BLANK. First snapshot is taken on the first cycle after rst deasserts.
//   - FSM per slot: BLANK (BLANK_CYCLES cycles: an inactive, seg = decode(snap[idx])) ->
//     ON (TICKS-BLANK_CYCLES cycles: an[idx] active, seg held) -> next slot.
//   - Slot counter width is $clog2(TICKS). It runs 0..TICKS-1; BLANK while cnt<BLANK_CYCLES.
//   - End of ON: idx <= idx+1, wrapping NUM_DIGITS-1 -> 0. On wrap, snap <= digits_in and
//     frame_start pulses in the same cycle that the new idx=0 BLANK begins.
//   - an and seg are registered and change only at slot/phase boundaries. Exactly one anode is
//     active at any time, never two. Anode moves are separated by >= BLANK_CYCLES dark cycles.
//   - Decode: 0-9 use the standard glyphs. Values 10-15 show a dash (g only), so bad BCD is
//     visible rather than silently wrong.
//   - Polarity: the internal active-high an/seg are XORed with {ACTIVE_LOW} at the output regs.
//   - Elaboration error if TICKS <= BLANK_CYCLES, BLANK_CYCLES < 1, or NUM_DIGITS < 1.
//   - rst mid-slot: all outputs are inactive the next cycle and scanning restarts at idx 0.
//   - digits_in changes between snapshots are ignored until the next wrap.
// CONFIGURATION
//   SCORE_LZB_EN defined: leading-zero blanking. It is evaluated on the snapshot at capture
//     time. Digits above the most-significant nonzero digit show all segments off while their
//     anode still scans, so the duty cycle is unchanged. Digit 0 is always shown, so a score of
//     0 displays "0". A dash digit (10-15) counts as nonzero.
//   SCORE_LZB_EN undefined: every digit is shown, including leading zeros ("00042").
// STRUCTURE
//   Package score_disp_pkg holds:
//     - the SEG_* glyph constants (0-9, DASH, OFF) in active-high {g..a} order;
//     - the scan_state_t enum {BLANK, ON};
//     - the DIGIT_W=4 constant.
//   Sub-module seg7_decode: combinational 4-bit -> 7-bit glyph lookup with a blank input.
//   All sequential logic lives in score_display_scan.
// TESTING  (bench params: CLK_HZ=1000, SLOT_HZ=100 -> TICKS=10, BLANK_CYCLES=2, ACTIVE_LOW=1)
//   1. Reset then release, digits_in=5'd{0,0,0,4,2}:
//      - frame_start pulses once;
//      - an=11111 for 2 cycles, then an=11110, seg=7'b0100100 ("2") for 8 cycles;
//      - next slot shows an=11101, seg=7'b0011001 ("4").
//   2. Steady scan over 100 cycles: an cycles through digits 0..4 and wraps to 0. Across all
//      cycles the number of zero bits in an is <= 1. frame_start period is exactly 50 cycles.
//   3. Change digits_in from 00042 to 12345 while idx=2: slots 3 and 4 still show 0. The new
//      value appears from the next frame's idx=0 slot onward, with units showing "5".
//   4. digits_in digit1=4'hC: that slot shows seg=7'b0111111 (dash); other digits unaffected.
//   5. SCORE_LZB_EN defined:
//      - 00042: digits 4..2 give seg=7'b1111111 while their anode is active;
//      - 00000: only digit 0 shows "0" (7'b1000000);
//      - 10000: all five digits are shown.
//   6. Assert rst for 1 cycle mid-ON at idx=3: the next cycle has an=11111, seg=7'b1111111,
//      frame_start=0, and the scan restarts at idx 0.

Source files
------------

// File: rtl/score_display_scan_pkg.sv
// Shared definitions for the score display scanner: digit width, glyph table, scan FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Glyphs are active-high in {g,f,e,d,c,b,a} order; polarity is applied at the output registers.
package score_disp_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  //                                         gfedcba
  localparam logic [SEG_W-1:0] SEG_0    = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1    = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2    = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3    = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4    = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5    = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6    = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7    = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8    = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9    = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/score_display_scan_if.sv
// Bundle between the score-to-digit converter and the display scanner.
// Latency: n/a (wires only).
// Backpressure: none; the scanner samples digits_in once per frame and never stalls.
//
// Signals: digits_in (digit i on [4i+3:4i]), an (anode enables), seg ({g..a}), frame_start.
// master: digit producer / observer.  slave: the scanner.
interface score_display_scan_if #(
  parameter int NUM_DIGITS = 5
);
  import score_disp_pkg::*;

  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]         an;
  logic [SEG_W-1:0]              seg;
  logic                          frame_start;

  modport master (
    output digits_in,
    input  an,
    input  seg,
    input  frame_start
  );

  modport slave (
    input  digits_in,
    output an,
    output seg,
    output frame_start
  );

endinterface

// File: rtl/score_display_scan_seg7_decode.sv
// BCD digit to active-high 7-segment glyph; values 10-15 show a dash so bad BCD is visible.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports: digit (4-bit value), blank (forces all segments off), seg ({g..a}, active-high).
module seg7_decode
  import score_disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               blank,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_OFF;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/score_display_scan.sv
// Time-multiplexed common-anode 7-segment scanner for the decimal score, one digit per slot.
// Latency: outputs registered; digits_in is captured at the frame wrap and shown from the next cycle.
// Backpressure: none; digits_in changes between frame wraps are ignored until the next snapshot.
//
// Ports: clk, rst (sync, active-high), dif (slave modport: digits_in in; an, seg, frame_start out).
// Each slot: BLANK_CYCLES dark cycles (segments already set), then the slot's anode for the rest.
// Optional build macro SCORE_LZB_EN: leading-zero blanking, evaluated once per snapshot.
module score_display_scan
  import score_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 5,
  parameter int CLK_HZ       = 50_000_000,
  parameter int SLOT_HZ      = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                clk,
  input  logic                rst,
  score_display_scan_if.slave dif
);

  localparam int TICKS = CLK_HZ / SLOT_HZ;
  localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] AN_POL  = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
  localparam logic [SEG_W-1:0]      SEG_POL = (ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : '0;

  if (TICKS <= BLANK_CYCLES) begin : g_bad_ticks
    $error("score_display_scan: slot length must exceed BLANK_CYCLES");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("score_display_scan: BLANK_CYCLES must be at least 1");
  end
  if (NUM_DIGITS < 1) begin : g_bad_digits
    $error("score_display_scan: NUM_DIGITS must be at least 1");
  end

  // Per-digit view of the incoming vector
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] din;
  assign din = dif.digits_in;

  // Scan state
  scan_state_t                        state_q, state_n;
  logic [CNT_W-1:0]                   cnt_q, cnt_n;
  logic [IDX_W-1:0]                   idx_q, idx_n;
  logic                               pend_q;   // snapshot owed after reset
  logic                               wrap;     // snapshot this edge; new frame begins

  // Frame snapshot and its leading-zero mask
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] snap_q, snap_n;
  logic [NUM_DIGITS-1:0]              lzb_q, lzb_n, lzb_cap;

  // Next-cycle output values (pre-polarity)
  logic [NUM_DIGITS-1:0]              an_d;
  logic [SEG_W-1:0]                   seg_d;
  logic [DIGIT_W-1:0]                 dig_n;
  logic                               blk_n;

  // Output registers
  logic [NUM_DIGITS-1:0]              an_q;
  logic [SEG_W-1:0]                   seg_q;
  logic                               fs_q;

`ifdef SCORE_LZB_EN
  // A digit is blanked when it and every digit above it are zero; digit 0 is never blanked.
  // Any nonzero nibble, including 10-15, stops the blanking.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    lzb_cap = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen       = seen | (din[i] != '0);
      lzb_cap[i] = ~seen;
    end
  end
`else
  assign lzb_cap = '0;
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b1;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      pend_q  <= 1'b0;
    end
  end

  // FSM: next state. The first cycle after reset is treated as a frame wrap so that the
  // display starts from a fresh snapshot at idx 0 with a frame_start pulse.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + 1'b1;
    idx_n   = idx_q;
    wrap    = 1'b0;
    if (pend_q) begin
      state_n = BLANK;
      cnt_n   = '0;
      idx_n   = '0;
      wrap    = 1'b1;
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_n = ON;
          end
        end
        ON: begin
          if (cnt_q == CNT_LAST) begin
            state_n = BLANK;
            cnt_n   = '0;
            if (idx_q == IDX_LAST) begin
              idx_n = '0;
              wrap  = 1'b1;
            end else begin
              idx_n = idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_n = BLANK;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign snap_n = wrap ? din : snap_q;
  assign lzb_n  = wrap ? lzb_cap : lzb_q;

  // FSM: outputs. Computed from next-state values so the registered an/seg line up with the
  // state they describe; seg is constant over a whole slot, an only changes at phase edges.
  assign dig_n = snap_n[idx_n];
  assign blk_n = lzb_n[idx_n];

  seg7_decode u_dec (
    .digit (dig_n),
    .blank (blk_n),
    .seg   (seg_d)
  );

  always_comb begin
    an_d = '0;
    if (state_n == ON) begin
      an_d[idx_n] = 1'b1;
    end
  end

  // Snapshot and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
      lzb_q  <= '0;
      an_q   <= AN_POL;
      seg_q  <= SEG_POL;
      fs_q   <= 1'b0;
    end else begin
      snap_q <= snap_n;
      lzb_q  <= lzb_n;
      an_q   <= an_d ^ AN_POL;
      seg_q  <= seg_d ^ SEG_POL;
      fs_q   <= wrap;
    end
  end

  assign dif.an          = an_q;
  assign dif.seg         = seg_q;
  assign dif.frame_start = fs_q;

endmodule

// File: tb/tb_score_display_scan.sv
// Directed bench for score_display_scan: TICKS=10, BLANK_CYCLES=2, active-low outputs.
// Expected per-cycle an/seg/frame_start are queued per frame and popped at each falling edge.
// Honours SCORE_LZB_EN for the leading-zero expectations.
module tb_score_display_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  score_display_scan_if #(.NUM_DIGITS(5)) dif ();

  score_display_scan #(
    .NUM_DIGITS   (5),
    .CLK_HZ       (1000),
    .SLOT_HZ      (100),
    .BLANK_CYCLES (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif.slave)
  );

  typedef struct packed {
    logic [4:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

`ifdef SCORE_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  // Active-low glyphs, {g..a}
  function automatic logic [6:0] glyph_low(input logic [3:0] d, input logic blk);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b0111111;
    endcase
    return blk ? 7'b1111111 : g;
  endfunction

  // True when the digit sits above the most significant nonzero digit (and is not digit 0)
  function automatic logic lz_blank(input logic [19:0] v, input int slot);
    logic z;
    z = (slot != 0);
    for (int j = slot; j < 5; j++) begin
      if (v[j*4 +: 4] != 4'd0) z = 1'b0;
    end
    return LZB && z;
  endfunction

  task automatic push_frame(input logic [19:0] shown, input int ncyc);
    exp_t e;
    for (int k = 0; k < ncyc; k++) begin
      int slot;
      int off;
      slot  = k / 10;
      off   = k % 10;
      e.an  = (off < 2) ? 5'b11111 : ~(5'b00001 << slot);
      e.seg = glyph_low(shown[slot*4 +: 4], lz_blank(shown, slot));
      e.fs  = (k == 0);
      sb.push_back(e);
    end
  endtask

  task automatic push_reset();
    exp_t e;
    e.an  = 5'b11111;
    e.seg = 7'b1111111;
    e.fs  = 1'b0;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    @(negedge clk);
    cyc++;
    e = sb.pop_front();
    checks++;
    assert (dif.an === e.an) else begin
      errors++;
      $error("FAIL %s an cyc=%0d got=%b exp=%b", tag, cyc, dif.an, e.an);
    end
    checks++;
    assert (dif.seg === e.seg) else begin
      errors++;
      $error("FAIL %s seg cyc=%0d got=%b exp=%b", tag, cyc, dif.seg, e.seg);
    end
    checks++;
    assert (dif.frame_start === e.fs) else begin
      errors++;
      $error("FAIL %s frame_start cyc=%0d got=%b exp=%b", tag, cyc, dif.frame_start, e.fs);
    end
    checks++;
    assert ($countones(~dif.an) <= 1) else begin
      errors++;
      $error("FAIL %s one_anode cyc=%0d got=%b exp=at most one low bit", tag, cyc, dif.an);
    end
  endtask

  // Runs ncyc cycles of a frame showing 'shown'; digits_in becomes next_in after cycle change_at
  task automatic run_frame(input logic [19:0] shown, input logic [19:0] next_in,
                           input int change_at, input int ncyc, input string tag);
    push_frame(shown, ncyc);
    for (int k = 0; k < ncyc; k++) begin
      pop_check(tag);
      if (k == change_at) dif.digits_in = next_in;
    end
  endtask

  initial begin
    dif.digits_in = 20'h00042;
    rst = 1'b1;
    for (int r = 0; r < 3; r++) begin
      push_reset();
      pop_check("reset");
    end
    rst = 1'b0;

    run_frame(20'h00042, 20'h00042, -1, 50, "first");
    run_frame(20'h00042, 20'h00042, -1, 50, "steady");
    // digits change while idx=2; slots 3 and 4 keep the old snapshot
    run_frame(20'h00042, 20'h12345, 24, 50, "midchg");
    run_frame(20'h12345, 20'h123C5, 10, 50, "newval");
    run_frame(20'h123C5, 20'h00000, 10, 50, "dash");
    run_frame(20'h00000, 20'h10000, 10, 50, "zero");
    run_frame(20'h10000, 20'h00042, 10, 50, "msd");

    // 35 cycles puts the last checked cycle at idx 3, mid-ON
    run_frame(20'h00042, 20'h00042, -1, 35, "prerst");
    rst = 1'b1;
    push_reset();
    pop_check("rst_mid");
    rst = 1'b0;
    run_frame(20'h00042, 20'h00042, -1, 50, "restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
